// File: rtl/dmem_port_arbiter_if.sv
// Requester-side bundle for one data-memory port: request fields in, grant/response out.
// Latency: none (pure wiring bundle).
// Backpressure: requester holds req and its fields stable until gnt pulses.
interface dmem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  logic              err;

  // Requester drives the request, arbiter answers with grant and completion.
  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between two requesters.
// Latency: req sampled in IDLE -> gnt next cycle (ACCESS) -> rvalid the cycle after (RESP).
// Backpressure: one transaction per 3 cycles; losers keep req high and wait for the next IDLE.
module dmem_port_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 64
) (
  input  logic              i_clk,
  input  logic              i_rst,
  dmem_port_arbiter_if.slave m0_if,
  dmem_port_arbiter_if.slave m1_if,
  output logic              o_mem_re,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  // Depth widened to the address width so the range test is unsigned over every address bit.
  localparam logic [ADDR_W-1:0] LP_DEPTH = ADDR_W'(MEM_DEPTH);

  logic [1:0]        r_state;
  logic              r_last_gnt;
  logic              r_id;
  logic              r_we;
  logic              r_oor;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [1:0]        r_gnt;
  logic [1:0]        r_rvalid;
  logic [1:0]        r_err;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;

  logic              w_any_req;
  logic              w_win_id;
  logic              w_win_we;
  logic [ADDR_W-1:0] w_win_addr;
  logic [DATA_W-1:0] w_win_wdata;
  logic              w_win_oor;
  logic              w_mem_en;
  logic              w_rd_hit;

  // Winner selection: a lone requester wins outright, a tie goes to the port not granted last.
  assign w_any_req   = m0_if.req | m1_if.req;
  assign w_win_id    = (m0_if.req & m1_if.req) ? ~r_last_gnt : m1_if.req;
  assign w_win_we    = w_win_id ? m1_if.we    : m0_if.we;
  assign w_win_addr  = w_win_id ? m1_if.addr  : m0_if.addr;
  assign w_win_wdata = w_win_id ? m1_if.wdata : m0_if.wdata;
  assign w_win_oor   = !(w_win_addr < LP_DEPTH);

  // The memory is only touched during ACCESS, and never for an out-of-range address.
  assign w_mem_en    = (r_state == S_ACCESS) & ~r_oor;
  assign w_rd_hit    = w_mem_en & ~r_we;
  assign o_mem_re    = w_mem_en & ~r_we;
  assign o_mem_we    = w_mem_en & r_we;
  assign o_mem_addr  = w_mem_en ? r_addr  : '0;
  assign o_mem_wdata = w_mem_en ? r_wdata : '0;

  assign m0_if.gnt    = r_gnt[0];
  assign m1_if.gnt    = r_gnt[1];
  assign m0_if.rvalid = r_rvalid[0];
  assign m1_if.rvalid = r_rvalid[1];
  assign m0_if.err    = r_err[0];
  assign m1_if.err    = r_err[1];
  assign m0_if.rdata  = r_rdata0;
  assign m1_if.rdata  = r_rdata1;

  // Sequencer IDLE -> ACCESS -> RESP -> IDLE; the winner's request is latched on leaving IDLE.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state    <= S_IDLE;
      r_last_gnt <= 1'b1;
      r_id       <= 1'b0;
      r_we       <= 1'b0;
      r_oor      <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_state    <= S_ACCESS;
            r_last_gnt <= w_win_id;
            r_id       <= w_win_id;
            r_we       <= w_win_we;
            r_oor      <= w_win_oor;
            r_addr     <= w_win_addr;
            r_wdata    <= w_win_wdata;
          end
        end
        S_ACCESS: r_state <= S_RESP;
        S_RESP:   r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  // Grant pulse is registered so it coincides exactly with the ACCESS cycle.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_gnt <= 2'b00;
    end else if (r_state == S_IDLE && w_any_req) begin
      r_gnt <= w_win_id ? 2'b10 : 2'b01;
    end else begin
      r_gnt <= 2'b00;
    end
  end

  // Completion is steered only to the latched port; read data is captured at the end of ACCESS.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_rvalid <= 2'b00;
      r_err    <= 2'b00;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else if (r_state == S_ACCESS) begin
      r_rvalid <= r_id ? 2'b10 : 2'b01;
      r_err    <= r_oor ? (r_id ? 2'b10 : 2'b01) : 2'b00;
      r_rdata0 <= (!r_id && w_rd_hit) ? i_mem_rdata : '0;
      r_rdata1 <= (r_id && w_rd_hit) ? i_mem_rdata : '0;
    end else begin
      r_rvalid <= 2'b00;
      r_err    <= 2'b00;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed + randomized bench for dmem_port_arbiter with a behavioural memory reference.
// Latency: checks gnt one cycle after a sampled request, completion one cycle later.
// Backpressure: exercises contention, late arrivals, withdrawal and reset mid-access.
`timescale 1ns/1ps
module tb_dmem_port_arbiter;
  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int MEM_DEPTH = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dmem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0_if ();
  dmem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1_if ();

  logic              mem_re;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  dmem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .m0_if       (m0_if),
    .m1_if       (m1_if),
    .o_mem_re    (mem_re),
    .o_mem_we    (mem_we),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .i_mem_rdata (mem_rdata)
  );

  // Data memory attached to the arbiter: write on posedge, combinational read.
  logic [DATA_W-1:0] mem     [MEM_DEPTH];
  logic [DATA_W-1:0] ref_mem [MEM_DEPTH];
  logic              mem_load;

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= ref_mem[i];
    end else if (mem_we && mem_addr < 32'(MEM_DEPTH)) begin
      mem[mem_addr[5:0]] <= mem_wdata;
    end
  end
  assign mem_rdata = (mem_addr < 32'(MEM_DEPTH)) ? mem[mem_addr[5:0]] : '0;

  int n_checks = 0;
  int n_errors = 0;

  logic              cur_we   [2];
  logic [ADDR_W-1:0] cur_addr [2];
  logic [DATA_W-1:0] cur_d    [2];

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic in_rng(input logic [ADDR_W-1:0] a);
    return a < 32'(MEM_DEPTH);
  endfunction

  function automatic logic [DATA_W-1:0] exp_rdata(input logic we, input logic [ADDR_W-1:0] a);
    return (!we && in_rng(a)) ? ref_mem[a[5:0]] : '0;
  endfunction

  task automatic model_apply(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    if (we && in_rng(a)) ref_mem[a[5:0]] = d;
  endtask

  task automatic drive(input int p, input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    cur_we[p] = we; cur_addr[p] = a; cur_d[p] = d;
    if (p == 0) begin
      m0_if.req = 1'b1; m0_if.we = we; m0_if.addr = a; m0_if.wdata = d;
    end else begin
      m1_if.req = 1'b1; m1_if.we = we; m1_if.addr = a; m1_if.wdata = d;
    end
  endtask

  task automatic drop(input int p);
    if (p == 0) m0_if.req = 1'b0;
    else        m1_if.req = 1'b0;
  endtask

  function automatic logic [DATA_W-1:0] rdata_of(input int p);
    return (p == 0) ? m0_if.rdata : m1_if.rdata;
  endfunction

  function automatic logic err_of(input int p);
    return (p == 0) ? m0_if.err : m1_if.err;
  endfunction

  task automatic chk_quiet(input string tag);
    chk(tag, {m0_if.gnt, m0_if.rvalid, m0_if.err, m1_if.gnt, m1_if.rvalid, m1_if.err,
              mem_re, mem_we, m0_if.rdata, m1_if.rdata, mem_addr, mem_wdata}, '0);
  endtask

  // Checks the ACCESS cycle for port p's transaction held in cur_*; returns expected response.
  task automatic chk_access(input string tag, input int p, output logic [DATA_W-1:0] er, output logic ee);
    logic in;
    in = in_rng(cur_addr[p]);
    chk({tag, "_gnt"}, {m1_if.gnt, m0_if.gnt}, (p == 1) ? 2'b10 : 2'b01);
    chk({tag, "_mem"}, {mem_we, mem_re, mem_addr, mem_wdata},
        {cur_we[p] & in, ~cur_we[p] & in, in ? cur_addr[p] : 32'h0, in ? cur_d[p] : 32'h0});
    er = exp_rdata(cur_we[p], cur_addr[p]);
    ee = ~in;
    model_apply(cur_we[p], cur_addr[p], cur_d[p]);
  endtask

  task automatic chk_resp(input string tag, input int p, input logic [DATA_W-1:0] er, input logic ee);
    chk({tag, "_rvalid"}, {m1_if.rvalid, m0_if.rvalid, m1_if.gnt, m0_if.gnt, mem_re, mem_we},
        {((p == 1) ? 2'b10 : 2'b01), 4'b0000});
    chk({tag, "_resp"}, {err_of(p), rdata_of(p), err_of(1 - p), rdata_of(1 - p)},
        {ee, er, 1'b0, 32'h0});
  endtask

  task automatic do_txn(input string tag, input int p, input logic we, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] er;
    logic              ee;
    drive(p, we, a, d);
    step();
    chk_access(tag, p, er, ee);
    drop(p);
    step();
    chk_resp(tag, p, er, ee);
    step();
    chk_quiet({tag, "_idle"});
  endtask

  initial begin
    logic [DATA_W-1:0] er;
    logic              ee;
    logic [DATA_W-1:0] er_c [2];
    logic              ee_c [2];
    int                gp;

    m0_if.req = 0; m0_if.we = 0; m0_if.addr = '0; m0_if.wdata = '0;
    m1_if.req = 0; m1_if.we = 0; m1_if.addr = '0; m1_if.wdata = '0;
    for (int i = 0; i < MEM_DEPTH; i++) ref_mem[i] = $urandom;
    mem_load = 1'b1;
    rst = 1'b0;
    step();
    step();
    chk_quiet("reset_state");
    mem_load = 1'b0;
    rst = 1'b1;
    step();
    chk_quiet("after_release");

    // Single write then read on port 0.
    do_txn("wr5", 0, 1'b1, 32'd5, 32'd30);
    do_txn("rd5", 0, 1'b0, 32'd5, 32'd0);
    chk("rd5_model", {32'h0, ref_mem[5]}, {32'h0, 32'd30});

    // Random single-port traffic across the valid range and a little beyond.
    for (int i = 0; i < 10; i++) begin
      do_txn("rand", $urandom_range(0, 1), 1'($urandom_range(0, 1)),
             32'($urandom_range(0, 70)), $urandom);
    end

    // Range boundary, including a high address bit that a truncated compare would miss.
    do_txn("oor64", 1, 1'b0, 32'd64, 32'd0);
    do_txn("ok63", 1, 1'b0, 32'd63, 32'd0);
    do_txn("oor_hi", 1, 1'b0, 32'h8000_0005, 32'd0);
    do_txn("oor_wr", 1, 1'b1, 32'd64, 32'hdead_beef);
    do_txn("ok63_rb", 0, 1'b0, 32'd63, 32'd0);

    // Port 1 arrives during port 0 ACCESS and waits for the next IDLE.
    drive(0, 1'b0, 32'd7, 32'd0);
    step();
    chk_access("late0", 0, er, ee);
    drop(0);
    drive(1, 1'b1, 32'd9, $urandom);
    step();
    chk_resp("late0", 0, er, ee);
    step();
    chk("late1_wait", {m1_if.gnt, m0_if.gnt, mem_we, mem_re}, 4'b0000);
    step();
    chk_access("late1", 1, er, ee);
    drop(1);
    step();
    chk_resp("late1", 1, er, ee);
    step();
    chk_quiet("late1_idle");

    // Withdrawal: port 1 pulses req only while port 0 is in RESP.
    drive(0, 1'b0, 32'd3, 32'd0);
    step();
    chk_access("wd0", 0, er, ee);
    drop(0);
    step();
    chk_resp("wd0", 0, er, ee);
    drive(1, 1'b1, 32'd10, ~ref_mem[10]);
    step();
    drop(1);
    chk_quiet("wd_idle0");
    for (int i = 0; i < 4; i++) begin
      step();
      chk_quiet("wd_idle");
    end
    chk("wd_mem10", {32'h0, mem[10]}, {32'h0, ref_mem[10]});

    // Asynchronous reset in the middle of a write ACCESS.
    drive(0, 1'b1, 32'd12, ~ref_mem[12]);
    step();
    chk("rst_pre_we", {mem_we, m0_if.gnt}, 2'b11);
    #2;
    rst = 1'b0;
    #1;
    chk_quiet("rst_async");
    drop(0);
    step();
    step();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_quiet("rst_after");
    end
    chk("rst_mem12", {32'h0, mem[12]}, {32'h0, ref_mem[12]});

    // Continuous contention from reset: m0 first, then strict alternation every 3 cycles.
    rst = 1'b0;
    step();
    drive(0, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 70)), $urandom);
    drive(1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 70)), $urandom);
    rst = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      step();
      gp = ((k - 1) / 3) % 2;
      case ((k - 1) % 3)
        0: begin
          chk_access("cont", gp, er_c[gp], ee_c[gp]);
          drive(gp, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 70)), $urandom);
        end
        1: chk_resp("cont", gp, er_c[gp], ee_c[gp]);
        default: chk("cont_idle", {m1_if.gnt, m0_if.gnt, m1_if.rvalid, m0_if.rvalid, mem_re, mem_we}, 6'b0);
      endcase
    end
    drop(0);
    drop(1);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
